data_transfer_exec: RTL and testbench

DATA_TRANSFER_EXEC -- requirements
Module: data_transfer_exec

---
 rtl/dtx_pkg.sv | 64 ++++++
 rtl/dtx_cw_unpack.sv | 35 +++
 rtl/data_transfer_exec.sv | 180 ++++++++++++++++++
 tb/tb_data_transfer_exec.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtx_pkg.sv
// dtx_pkg -- shared definitions for the data-transfer execution block.
//   * bit positions of every field inside the 96-bit control word
//   * cw_t        : raw 96-bit control word
//   * cw_fields_t : control word split into named fields
//   * state_t     : sequencer states (IDLE, ADDR, ACCESS, WB)
package dtx_pkg;

    localparam int CW_W        = 96;
    localparam int DA_LSB      = 0;
    localparam int AA_LSB      = 5;
    localparam int BA_LSB      = 10;
    localparam int FS_LSB      = 15;
    localparam int PS_LSB      = 20;
    localparam int EN_STAT_BIT = 22;
    localparam int CS_BIT      = 23;
    localparam int O_EN_BIT    = 24;
    localparam int W_EN_BIT    = 25;
    localparam int PC_SEL_BIT  = 26;
    localparam int B_SEL_BIT   = 27;
    localparam int EN_PC_ADDR_BIT = 28;
    localparam int EN_PC_BIT   = 29;
    localparam int EN_ADDR_BIT = 30;
    localparam int EN_B_BIT    = 31;
    localparam int EN_ALU_BIT  = 32;
    localparam int IL_BIT      = 33;
    localparam int WR_BIT      = 34;
    localparam int K_LSB       = 35;
    localparam int K_W         = 61;

    // Writes to this register index are discarded (hard-wired zero register).
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef logic [CW_W-1:0] cw_t;

    typedef struct packed {
        logic [K_W-1:0] k;
        logic           wr;
        logic           il;
        logic           en_alu;
        logic           en_b;
        logic           en_addr;
        logic           en_pc;
        logic           en_pc_addr;
        logic           b_sel;
        logic           pc_sel;
        logic           w_en;
        logic           o_en;
        logic           cs;
        logic           en_stat;
        logic [1:0]     ps;
        logic [4:0]     fs;
        logic [4:0]     ba;
        logic [4:0]     aa;
        logic [4:0]     da;
    } cw_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WB     = 2'd3
    } state_t;

endpackage

// File: rtl/dtx_cw_unpack.sv
// dtx_cw_unpack -- purely combinational split of a control word into
// named fields.
//   cw     : in  - raw 96-bit control word
//   fields : out - the same bits, grouped by field name
module dtx_cw_unpack
    import dtx_pkg::*;
(
    input  cw_t        cw,
    output cw_fields_t fields
);

    always_comb begin
        fields            = '0;
        fields.da         = cw[DA_LSB +: 5];
        fields.aa         = cw[AA_LSB +: 5];
        fields.ba         = cw[BA_LSB +: 5];
        fields.fs         = cw[FS_LSB +: 5];
        fields.ps         = cw[PS_LSB +: 2];
        fields.en_stat    = cw[EN_STAT_BIT];
        fields.cs         = cw[CS_BIT];
        fields.o_en       = cw[O_EN_BIT];
        fields.w_en       = cw[W_EN_BIT];
        fields.pc_sel     = cw[PC_SEL_BIT];
        fields.b_sel      = cw[B_SEL_BIT];
        fields.en_pc_addr = cw[EN_PC_ADDR_BIT];
        fields.en_pc      = cw[EN_PC_BIT];
        fields.en_addr    = cw[EN_ADDR_BIT];
        fields.en_b       = cw[EN_B_BIT];
        fields.en_alu     = cw[EN_ALU_BIT];
        fields.il         = cw[IL_BIT];
        fields.wr         = cw[WR_BIT];
        fields.k          = cw[K_LSB +: K_W];
    end

endmodule

// File: rtl/data_transfer_exec.sv
// data_transfer_exec -- executes one load or store described by a control word.
//
// Handshake: a control word is taken on a rising clock edge where
// cw_valid && cw_ready; cw_ready is high only in IDLE (and during reset).
// Words with CS=0 are consumed without effect.
//
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   cw_valid/cw_ready/cw    : control-word handshake and 96-bit word
//   a_data, b_data          : base address operand and store data
//   mem_*                   : memory address/data/strobes, mem_ready completes ACCESS
//   rf_wr, rf_da, rf_wdata  : register-file write-back (DA=31 suppressed)
//   done                    : one-cycle completion pulse
//   err                     : sticky memory timeout flag
//   dbg_state, dbg_fields   : current state and latched control-word fields
//
// Build option: define DTX_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYCLES cycles without mem_ready; otherwise ACCESS waits forever
// and err is constant 0.
module data_transfer_exec
    import dtx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cw_valid,
    output logic        cw_ready,
    input  logic [95:0] cw,
    input  logic [63:0] a_data,
    input  logic [63:0] b_data,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic        mem_oe,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic        rf_wr,
    output logic [4:0]  rf_da,
    output logic [63:0] rf_wdata,
    output logic        done,
    output logic        err,
    output state_t      dbg_state,
    output cw_fields_t  dbg_fields
);

    state_t      state_q, state_d;
    cw_t         cw_q, cw_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [63:0] rdata_q, rdata_d;
    cw_fields_t  f;
    logic        is_load;

    dtx_cw_unpack u_unpack (
        .cw     (cw_q),
        .fields (f)
    );

    // W_En wins when both strobes are set, so such a word is a store.
    assign is_load = f.wr & ~f.w_en;

`ifdef DTX_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cw_d        = cw_q;
        a_d         = a_q;
        b_d         = b_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
`ifdef DTX_TIMEOUT_EN
        wait_d      = wait_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cw_valid && cw[CS_BIT]) begin
                    cw_d    = cw;
                    a_d     = a_data;
                    b_d     = b_data;
                    state_d = ST_ADDR;
`ifdef DTX_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_ADDR: begin
                mem_addr_d  = a_q + {3'b000, f.k};
                mem_wdata_d = b_q;
                state_d     = ST_ACCESS;
`ifdef DTX_TIMEOUT_EN
                wait_d      = '0;
`endif
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    if (is_load) begin
                        rdata_d = mem_rdata;
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef DTX_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cw_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef DTX_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cw_q        <= cw_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
`ifdef DTX_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    // Strobes and write-back are decoded from the state register so reset
    // clears them immediately; a store completes combinationally on the
    // ACCESS cycle that sees mem_ready.
    always_comb begin
        cw_ready  = (state_q == ST_IDLE);
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_cs    = (state_q == ST_ACCESS);
        mem_we    = (state_q == ST_ACCESS) & f.w_en;
        mem_oe    = (state_q == ST_ACCESS) & f.o_en;
        rf_wr     = (state_q == ST_WB) & (f.da != ZERO_REG);
        rf_da     = (state_q == ST_WB) ? f.da : 5'd0;
        rf_wdata  = (state_q == ST_WB) ? rdata_q : 64'd0;
        done      = ((state_q == ST_ACCESS) & mem_ready & ~is_load) | (state_q == ST_WB);
`ifdef DTX_TIMEOUT_EN
        err       = err_q;
`else
        err       = 1'b0;
`endif
        dbg_state  = state_q;
        dbg_fields = f;
    end

endmodule

// File: tb/tb_data_transfer_exec.sv
// tb_data_transfer_exec -- directed bench for data_transfer_exec.
// Expected write-back results go into exp_q when a word is offered and are
// popped by the monitor on every done pulse. Cycle 1 is the acceptance cycle.
module tb_data_transfer_exec;
    import dtx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cw_valid;
    logic        cw_ready;
    logic [95:0] cw;
    logic [63:0] a_data, b_data;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_cs, mem_we, mem_oe, mem_ready;
    logic        rf_wr;
    logic [4:0]  rf_da;
    logic [63:0] rf_wdata;
    logic        done, err;
    state_t      dbg_state;
    cw_fields_t  dbg_fields;

    always #5 clk = ~clk;

    data_transfer_exec #(.TIMEOUT_CYCLES(4)) dut (
        .clock      (clk),
        .reset      (reset),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .cw         (cw),
        .a_data     (a_data),
        .b_data     (b_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_oe     (mem_oe),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .rf_wr      (rf_wr),
        .rf_da      (rf_da),
        .rf_wdata   (rf_wdata),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state),
        .dbg_fields (dbg_fields)
    );

    int tests = 0;
    int fails = 0;
    logic [69:0] exp_q[$];   // {rf_wr, rf_da, rf_wdata}

    logic [63:0] snap_addr, snap_wdata;
    logic        snap_we, snap_oe, snap_valid;
    int          lat;
    logic        saw_done, saw_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] make_cw(input logic [4:0] da, input logic wr,
                                            input logic o_en, input logic w_en,
                                            input logic cs, input logic [60:0] k);
        logic [95:0] c;
        c        = '0;
        c[4:0]   = da;
        c[23]    = cs;
        c[24]    = o_en;
        c[25]    = w_en;
        c[34]    = wr;
        c[95:35] = k;
        return c;
    endfunction

    // Monitor: every done pops one expected write-back.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    logic [69:0] e;
                    e = exp_q.pop_front();
                    check("rf_wr", {63'd0, rf_wr}, {63'd0, e[69]});
                    if (e[69]) begin
                        check("rf_da", {59'd0, rf_da}, {59'd0, e[68:64]});
                        check("rf_wdata", rf_wdata, e[63:0]);
                    end
                end
            end else if (rf_wr) begin
                check("rf_wr_without_done", {63'd0, rf_wr}, 64'd0);
            end
        end
    end

    task automatic accept(input logic [95:0] w, input logic [63:0] a, input logic [63:0] b);
        @(posedge clk); #1;
        cw_valid = 1'b1;
        cw       = w;
        a_data   = a;
        b_data   = b;
        @(negedge clk);
        check("cw_ready_idle", {63'd0, cw_ready}, 64'd1);
        @(posedge clk); #1;
        cw_valid = 1'b0;
        cw       = '0;
        a_data   = {$urandom, $urandom};
        b_data   = {$urandom, $urandom};
    endtask

    // Runs from cycle 2 until done or err, raising mem_ready after
    // ready_delay ACCESS cycles; bounded at 40 cycles.
    task automatic run(input int ready_delay);
        int cyc;
        int waited;
        cyc = 1; waited = 0; lat = 0; saw_done = 0; saw_err = 0; snap_valid = 0;
        mem_ready = (ready_delay == 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (err) begin
                saw_err = 1; lat = cyc;
                break;
            end
            check("cw_ready_busy", {63'd0, cw_ready}, 64'd0);
            if (mem_cs) begin
                if (!snap_valid) begin
                    snap_valid = 1; snap_addr = mem_addr; snap_wdata = mem_wdata;
                    snap_we = mem_we; snap_oe = mem_oe;
                end else begin
                    check("hold_addr", mem_addr, snap_addr);
                    check("hold_we", {63'd0, mem_we}, {63'd0, snap_we});
                    check("hold_wdata", mem_wdata, snap_wdata);
                end
            end
            if (done) begin
                saw_done = 1; lat = cyc;
                break;
            end
            if (mem_cs && !mem_ready) waited++;
            @(posedge clk); #1;
            if (waited == ready_delay) mem_ready = 1'b1;
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] a, k64, rd, addr_before;
        logic [4:0]  da;

        // Reset state
        reset = 1'b1; cw_valid = 1'b0; cw = '0; a_data = '0; b_data = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        #12;
        check("rst_cw_ready", {63'd0, cw_ready}, 64'd1);
        check("rst_mem_cs", {63'd0, mem_cs}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_rf_wr", {63'd0, rf_wr}, 64'd0);
        @(negedge clk); reset = 1'b0;

        // Load, memory ready immediately
        mem_rdata = 64'hDEAD;
        exp_q.push_back({1'b1, 5'd3, 64'hDEAD});
        accept(make_cw(5'd3, 1, 1, 0, 1, 61'h10), 64'h1000, 64'h77);
        run(0);
        check("load_done", {63'd0, saw_done}, 64'd1);
        check("load_latency", lat, 4);
        check("load_addr", snap_addr, 64'h1010);
        check("load_oe", {63'd0, snap_oe}, 64'd1);
        check("load_we", {63'd0, snap_we}, 64'd0);

        // Store
        exp_q.push_back({1'b0, 5'd0, 64'd0});
        accept(make_cw(5'd7, 0, 0, 1, 1, 61'h1FF), 64'h0, 64'h55);
        run(0);
        check("store_latency", lat, 3);
        check("store_addr", snap_addr, 64'h1FF);
        check("store_we", {63'd0, snap_we}, 64'd1);
        check("store_wdata", snap_wdata, 64'h55);

        // Store with memory held off for 5 cycles
        exp_q.push_back({1'b0, 5'd0, 64'd0});
        accept(make_cw(5'd2, 0, 0, 1, 1, 61'h20), 64'h4000, 64'hABCD);
        run(5);
        check("wait_latency", lat, 8);
        check("wait_addr", snap_addr, 64'h4020);

        // Address wrap
        rd = {$urandom, $urandom}; mem_rdata = rd;
        exp_q.push_back({1'b1, 5'd9, rd});
        accept(make_cw(5'd9, 1, 1, 0, 1, 61'h10), 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
        run(0);
        check("wrap_addr", snap_addr, 64'h8);
        check("wrap_latency", lat, 4);

        // Load into the zero register
        exp_q.push_back({1'b0, 5'd31, 64'd0});
        accept(make_cw(5'd31, 1, 1, 0, 1, 61'h4), 64'h100, 64'h0);
        run(0);
        check("zreg_latency", lat, 4);

        // WR with both strobes set behaves as a store
        exp_q.push_back({1'b0, 5'd0, 64'd0});
        accept(make_cw(5'd4, 1, 1, 1, 1, 61'h8), 64'h200, 64'h99);
        run(0);
        check("both_latency", lat, 3);
        check("both_we", {63'd0, snap_we}, 64'd1);

        // CS=0 word is consumed and ignored
        addr_before = mem_addr;
        accept(make_cw(5'd5, 1, 1, 0, 0, 61'h40), 64'h3000, 64'h0);
        repeat (3) begin
            @(negedge clk);
            check("cs0_ready", {63'd0, cw_ready}, 64'd1);
            check("cs0_mem_cs", {63'd0, mem_cs}, 64'd0);
            check("cs0_addr", mem_addr, addr_before);
        end

        // Reset during ACCESS
        mem_ready = 1'b0;
        accept(make_cw(5'd6, 0, 0, 1, 1, 61'h30), 64'h5000, 64'h1234);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_cs", {63'd0, mem_cs}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cs", {63'd0, mem_cs}, 64'd0);
        check("mid_rst_we", {63'd0, mem_we}, 64'd0);
        check("mid_rst_addr", mem_addr, 64'd0);
        check("mid_rst_wdata", mem_wdata, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_ready", {63'd0, cw_ready}, 64'd1);
        @(negedge clk); reset = 1'b0;

        // Random loads (the first also confirms recovery after reset)
        for (int i = 0; i < 3; i++) begin
            a   = {$urandom, $urandom};
            k64 = {32'd0, $urandom};
            da  = 5'($urandom_range(0, 30));
            rd  = {$urandom, $urandom}; mem_rdata = rd;
            exp_q.push_back({1'b1, da, rd});
            accept(make_cw(da, 1, 1, 0, 1, k64[60:0]), a, 64'h0);
            run(int'($urandom_range(0, 3)));
            check("rand_done", {63'd0, saw_done}, 64'd1);
            check("rand_addr", snap_addr, a + k64);
        end

`ifdef DTX_TIMEOUT_EN
        // Timeout: no mem_ready ever
        accept(make_cw(5'd8, 1, 1, 0, 1, 61'h0), 64'h700, 64'h0);
        run(1000);
        check("to_err", {63'd0, saw_err}, 64'd1);
        check("to_no_done", {63'd0, saw_done}, 64'd0);
        check("to_latency", lat, 7);
        check("to_mem_cs", {63'd0, mem_cs}, 64'd0);
        rd = 64'h0BAD; mem_rdata = rd;
        exp_q.push_back({1'b1, 5'd8, rd});
        accept(make_cw(5'd8, 1, 1, 0, 1, 61'h0), 64'h700, 64'h0);
        check("to_err_clear", {63'd0, err}, 64'd0);
        run(0);
        check("to_recover", {63'd0, saw_done}, 64'd1);
`endif

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
